// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the Common Data Bus arbitration slice.
// The CDB packet layout matches what the RS, ROB and register-status consumers expect.
package cdb_arbiter_pkg;

    localparam int NUM_UNITS = 4;

    localparam int FU_ALU = 0;
    localparam int FU_MUL = 1;
    localparam int FU_DIV = 2;
    localparam int FU_LSU = 3;

    typedef struct packed {
        logic        valid;
        logic [5:0]  tag;
        logic [4:0]  rob_entry;
        logic [31:0] data;
        logic        is_branch;
        logic        branch_taken;
        logic [31:0] branch_target;
        logic        exception;
    } cdb_packet_s;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin pick: the first requester at or after ptr_i,
// wrapping modulo n_p.
module rr_priority_pick #(
    parameter  int n_p      = 4,
    localparam int ptr_w_lp = $clog2(n_p)
) (
    input  logic [n_p-1:0]      req_i,
    input  logic [ptr_w_lp-1:0] ptr_i,
    output logic [n_p-1:0]      grant_o,
    output logic [ptr_w_lp-1:0] idx_o,
    output logic                any_o
);

    int                  j;
    logic [ptr_w_lp-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        cand    = '0;
        for (int k = 0; k < n_p; k++) begin
            j = int'(ptr_i) + k;
            if (j >= n_p) j = j - n_p;
            cand = ptr_w_lp'(j);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single Common Data Bus: grants one functional
// unit per cycle and registers its packet as the next-cycle broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int num_units_p = NUM_UNITS,
    localparam int ptr_w_lp    = $clog2(num_units_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             flush_i,
    input  logic                             cdb_ready_i,
    input  cdb_packet_s [num_units_p-1:0]    fu_packet_i,
    output logic [num_units_p-1:0]           grant_o,
    output cdb_packet_s                      cdb_o,
    output logic                             busy_o
);

    logic [num_units_p-1:0] req;
    logic [num_units_p-1:0] pick_grant;
    logic [ptr_w_lp-1:0]    pick_idx;
    logic                   pick_any;
    logic [ptr_w_lp-1:0]    prio_r;
    logic                   grant_en;

    always_comb begin
        req = '0;
        for (int i = 0; i < num_units_p; i++) req[i] = fu_packet_i[i].valid;
    end

    rr_priority_pick #(.n_p(num_units_p)) u_pick (
        .req_i   (req),
        .ptr_i   (prio_r),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Grant depends only on request valids, pointer and the gating inputs, never on cdb_o.
    assign grant_en = pick_any & cdb_ready_i & ~flush_i & ~reset_i;
    assign grant_o  = grant_en ? pick_grant : '0;
    assign busy_o   = |req;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_r <= '0;
            cdb_o  <= '0;
        end else if (grant_en) begin
            prio_r      <= (pick_idx == ptr_w_lp'(num_units_p - 1)) ? '0
                                                                     : pick_idx + ptr_w_lp'(1);
            cdb_o       <= fu_packet_i[pick_idx];
            cdb_o.valid <= 1'b1;
        end else begin
            // Payload fields are held; only the valid bit drops.
            cdb_o.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants checked inline, broadcasts checked
// by a scoreboard monitor fed from the stimulus.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic              clk_i = 1'b0;
    logic              reset_i, flush_i, cdb_ready_i;
    cdb_packet_s [3:0] fu;
    logic [3:0]        grant_o;
    cdb_packet_s       cdb_o;
    logic              busy_o;

    cdb_arbiter #(.num_units_p(4)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .cdb_ready_i (cdb_ready_i),
        .fu_packet_i (fu),
        .grant_o     (grant_o),
        .cdb_o       (cdb_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk  = 0;
    int          n_fail = 0;
    cdb_packet_s exp_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic cdb_packet_s mk(input int u, input logic [5:0] tag, input logic [31:0] data);
        cdb_packet_s p;
        p               = '0;
        p.valid         = 1'b1;
        p.tag           = tag;
        p.rob_entry     = 5'(u + 4);
        p.data          = data;
        p.is_branch     = (u == 0);
        p.branch_taken  = (u == 0);
        p.branch_target = data ^ 32'hFFFF_0000;
        p.exception     = (u == 3);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Check the combinational grant, queue the broadcast it implies, advance one cycle.
    task automatic step(input string nm, input logic [3:0] exp_g);
        cdb_packet_s e;
        #1;
        chk(nm, grant_o, exp_g);
        for (int i = 0; i < 4; i++) begin
            if (exp_g[i]) begin
                e       = fu[i];
                e.valid = 1'b1;
                exp_q.push_back(e);
            end
        end
        tick();
    endtask

    always @(negedge clk_i) begin : monitor
        cdb_packet_s e;
        if (cdb_o.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL cdb_unexpected: got %0h, expected no broadcast", cdb_o);
            end else begin
                e = exp_q.pop_front();
                chk("cdb_o", cdb_o, e);
            end
        end
    end

    initial begin
        reset_i     = 1'b1;
        flush_i     = 1'b0;
        cdb_ready_i = 1'b1;
        fu          = '0;
        fu[0]       = mk(0, 6'd1, 32'h0000_0001);
        #2;
        chk("grant_in_reset", grant_o, 4'b0000);
        chk("busy_in_reset", busy_o, 1'b1);
        tick();
        tick();
        chk("reset_cdb_valid", cdb_o.valid, 1'b0);
        reset_i = 1'b0;
        fu      = '0;

        for (int c = 0; c < 5; c++) begin
            step("idle_grant", 4'b0000);
            chk("idle_cdb_valid", cdb_o.valid, 1'b0);
            chk("idle_prio", dut.prio_r, 2'd0);
        end
        chk("idle_busy", busy_o, 1'b0);

        fu[FU_MUL] = mk(FU_MUL, 6'd3, 32'h0000_0C8F);
        #1 chk("mul_busy", busy_o, 1'b1);
        step("mul_grant", 4'b0010);
        fu[FU_MUL].valid = 1'b0;
        chk("mul_prio", dut.prio_r, 2'd2);
        chk("mul_cdb_tag", cdb_o.tag, 6'd3);
        chk("mul_cdb_data", cdb_o.data, 32'h0000_0C8F);

        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rst_prio", dut.prio_r, 2'd0);

        for (int u = 0; u < 4; u++) fu[u] = mk(u, 6'(8 + u), 32'h1000_0000 + 32'(u * 32'h111));
        step("rr_g0", 4'b0001);
        step("rr_g1", 4'b0010);
        step("rr_g2", 4'b0100);
        step("rr_g3", 4'b1000);
        step("rr_g0b", 4'b0001);
        fu = '0;
        chk("rr_prio", dut.prio_r, 2'd1);

        fu[2] = mk(2, 6'd20, 32'hABCD_0002);
        step("setup_g2", 4'b0100);
        chk("wrap_prio3", dut.prio_r, 2'd3);
        fu[0] = mk(0, 6'd21, 32'hABCD_0010);
        fu[2] = mk(2, 6'd22, 32'hABCD_0012);
        step("wrap_g0", 4'b0001);
        fu[0].valid = 1'b0;
        chk("wrap_prio1", dut.prio_r, 2'd1);
        step("wrap_g2", 4'b0100);
        fu[2].valid = 1'b0;
        chk("wrap_prio3b", dut.prio_r, 2'd3);

        fu[2]       = mk(2, 6'd30, 32'h0BAD_F00D);
        cdb_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) step("bp_hold", 4'b0000);
        chk("bp_cdb_valid", cdb_o.valid, 1'b0);
        chk("bp_prio", dut.prio_r, 2'd3);
        cdb_ready_i = 1'b1;
        step("bp_release", 4'b0100);
        fu[2].valid = 1'b0;

        fu[0]   = mk(0, 6'd40, 32'h4000_0040);
        flush_i = 1'b1;
        step("flush_grant", 4'b0000);
        chk("flush_cdb_valid", cdb_o.valid, 1'b0);
        chk("flush_prio", dut.prio_r, 2'd3);
        cdb_ready_i = 1'b0;
        step("flush_nordy_grant", 4'b0000);
        flush_i     = 1'b0;
        cdb_ready_i = 1'b1;
        step("post_flush_g0", 4'b0001);
        fu[0].valid = 1'b0;
        chk("post_flush_prio", dut.prio_r, 2'd1);

        fu[3]   = mk(3, 6'd50, 32'h5000_0050);
        reset_i = 1'b1;
        #1 chk("midrst_grant", grant_o, 4'b0000);
        tick();
        reset_i = 1'b0;
        chk("midrst_cdb_valid", cdb_o.valid, 1'b0);
        chk("midrst_prio", dut.prio_r, 2'd0);
        step("after_rst_g3", 4'b1000);
        fu[3].valid = 1'b0;
        chk("after_rst_prio_wrap", dut.prio_r, 2'd0);

        fu = '0;
        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter sharing the single Common Data Bus among the functional units: ALU, multiplier, divider and load/store. Each unit presents a completed `cdb_packet_s` and holds it until granted. The arbiter grants at most one unit per cycle and registers the winning packet onto the CDB broadcast. It sits between the functional units' `result_o` / `cdb_grant_i` pairs and the reservation stations, ROB and register-status consumers.

## Interface
- `num_units_p`, default 4: number of requesting functional units; must be ≥2.
- `clk_i`  in  1: clock.
- `reset_i`  in  1: synchronous, active-high reset.
- `flush_i`  in  1: pipeline flush on branch mispredict or exception.
- `cdb_ready_i`  in  1: consumers can accept a broadcast this cycle; 0 blocks all grants.
- `fu_packet_i`  in  `num_units_p` × `cdb_packet_s`: per-unit result; `.valid` is the request.
- `grant_o`  out  `num_units_p`: one-hot or zero; combinational grant, fed to each unit's `cdb_grant_i`.
- `cdb_o`  out  `cdb_packet_s`: registered broadcast packet.
- `busy_o`  out  1: any unit requesting (OR of request valids).

## Operation
- Request: unit i is requesting when `fu_packet_i[i].valid`=1. Units hold packet and valid stable until granted.
- Arbitration, combinational:
  - Among requesting units, pick the first at or after `prio_r`, with modulo `num_units_p` wrap.
  - Raise `grant_o` for that unit only.
  - `grant_o`=0 when `cdb_ready_i`=0, `flush_i`=1, or no requests.
- Priority pointer `prio_r`, width clog2(`num_units_p`):
  - On a grant to unit g, `prio_r` ← (g+1) mod `num_units_p`. From `num_units_p`−1 it wraps to 0.
  - Unchanged when there is no grant.
- Broadcast register, next cycle:
  - On a grant to unit g, `cdb_o` ← `fu_packet_i[g]` with `.valid`=1.
  - Otherwise `cdb_o.valid` ← 0 and the other fields are don't-care; the implementation holds them.
- Flush: `cdb_o.valid` ← 0 next cycle and no grant this cycle. `prio_r` is unchanged. Units are flushed by their own logic.
- Fairness: a continuously requesting unit is granted within `num_units_p` grant cycles.
- Simultaneous `flush_i` and `cdb_ready_i`=0: flush rules apply.
- Reset mid-operation: pending requests are not granted during reset. Arbitration resumes the cycle after reset deasserts, with `prio_r`=0.

## Timing
- Reset values:
  - `cdb_o` all zeros (`.valid`=0).
  - `prio_r`=0.
  - `grant_o`=0 while `reset_i`=1.
  - `busy_o` follows the inputs.
- Latency: grant in cycle t (same cycle as the request, if it wins). `cdb_o.valid`=1 with that packet in cycle t+1, for exactly one cycle per grant.
- Throughput: one broadcast per cycle. Back-to-back grants to different units produce back-to-back `cdb_o` packets.
- A unit granted in cycle t drops valid in t+1, as the multiplier moves HOLDING→IDLE. The arbiter does not re-grant it on stale data.
- No combinational path from `cdb_o` to `grant_o`. `grant_o` depends only on `fu_packet_i[*].valid`, `prio_r`, `cdb_ready_i`, `flush_i` and `reset_i`.

## Structure
- `cdb_packet_s` lives in the shared `structs.svh`. Fields: valid, tag, rob_entry, data, is_branch, branch_taken, branch_target, exception.
- The `num_units_p` default and functional-unit index constants (ALU=0, MUL=1, DIV=2, LSU=3) go in the shared package.
- Sub-module `rr_priority_pick`:
  - Purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
- `cdb_arbiter` holds `prio_r`, the `cdb_o` register and the gating logic.

## Test plan
- Reset then idle: `cdb_o.valid`=0, `grant_o`=0, `prio_r`=0 for 5 cycles with no requests.
- Single request:
  - Stimulus: MUL (unit 1) valid with data=0x0000_0C8F, tag=3.
  - Cycle t: `grant_o`=4'b0010.
  - Cycle t+1: `cdb_o`={valid 1, tag 3, data 0x0000_0C8F}.
  - Then `prio_r`=2.
- All four units requesting continuously from `prio_r`=0: grants 0,1,2,3,0 on consecutive cycles, and `cdb_o` carries each packet one cycle later.
- Wrap-around:
  - Stimulus: `prio_r`=3; units 0 and 2 requesting, unit 3 idle.
  - Grant unit 0, then unit 2.
  - `prio_r` goes 3→1→3.
- Backpressure: `cdb_ready_i`=0 for 3 cycles with unit 2 requesting gives no grant and `cdb_o.valid`=0. Raising `cdb_ready_i` grants unit 2 that cycle.
- Flush: `flush_i`=1 in the cycle unit 0 requests gives no grant, `cdb_o.valid`=0 next cycle and `prio_r` unchanged. Asserting reset in the cycle after a grant clears `cdb_o.valid` and sets `prio_r`=0.
